// File: rtl/div_radix2_pkg.sv
// Shared constants for the radix-2 divider: FSM encoding, handshake levels and
// default sizes.
package div_radix2_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_radix2_if.sv
// EX-stage divide handshake: the initiator holds start_i with operands until
// the divider raises ready_o.
interface div_radix2_if #(
   parameter int WIDTH = 32
);
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      // NOTE: every output gets a value on every path, so no latch is inferred.
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
      // The remainder keeps its full width so divisors above 2**(WIDTH-1) work.
      if (diff[WIDTH]) begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_radix2.sv
// Iterative signed/unsigned divider, one quotient bit per clock. Result is
// {remainder, quotient}, valid while ready_o is high.
module div_radix2
   import div_radix2_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input logic         clk,
   input logic         rst,
   div_radix2_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_e           state;
   logic [CNT_W-1:0]     count;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     divisor;
   logic                 sign1;
   logic                 sign2;
   logic [2*WIDTH-1:0]   result_q;
   logic                 ready_q;

   logic [WIDTH-1:0]     rem_nxt;
   logic [WIDTH-1:0]     quo_nxt;
   logic [WIDTH-1:0]     abs1;
   logic [WIDTH-1:0]     abs2;
   logic [WIDTH-1:0]     rem_fix;
   logic [WIDTH-1:0]     quo_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   // Magnitudes only for signed operations; the most negative value maps to itself.
   assign abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

   assign quo_fix = (sign1 ^ sign2) ? -quo_nxt : quo_nxt;
   assign rem_fix = sign1 ? -rem_nxt : rem_nxt;

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every branch sees
      // pre-edge values; the datapath registers are reset too, so nothing is X
      // after reset.
      if (rst) begin
         state    <= DIV_FREE;
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         result_q <= '0;
         ready_q  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            DIV_FREE: begin
               result_q <= '0;
               ready_q  <= DIV_RESULT_NOT_READY;
               if (bus.start_i == DIV_START && !bus.annul_i) begin
                  sign1   <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                  sign2   <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
                  quo     <= abs1;
                  divisor <= abs2;
                  rem     <= '0;
                  count   <= '0;
                  state   <= (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
               end
            end

            DIV_BYZERO: begin
               result_q <= '0;
               if (bus.annul_i) begin
                  state <= DIV_FREE;
               end else begin
                  ready_q <= DIV_RESULT_READY;
                  state   <= DIV_END;
               end
            end

            DIV_ON: begin
               if (bus.annul_i) begin
                  result_q <= '0;
                  ready_q  <= DIV_RESULT_NOT_READY;
                  state    <= DIV_FREE;
               end else begin
                  rem   <= rem_nxt;
                  quo   <= quo_nxt;
                  count <= count + CNT_W'(1);
                  if (count == LAST_STEP) begin
                     result_q <= {rem_fix, quo_fix};
                     ready_q  <= DIV_RESULT_READY;
                     state    <= DIV_END;
                  end
               end
            end

            DIV_END: begin
               if (bus.start_i == DIV_STOP || bus.annul_i) begin
                  result_q <= '0;
                  ready_q  <= DIV_RESULT_NOT_READY;
                  state    <= DIV_FREE;
               end
            end

            default: state <= DIV_FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: a vector table fed through a scoreboard,
// plus hand-written annul, hold and asynchronous-reset sequences.
module tb_div_radix2;
   import div_radix2_pkg::*;

   localparam int W = 32;

   typedef struct {
      string        name;
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2*W-1:0] exp;
      int           lat;
   } vec_t;

   typedef struct {
      string          name;
      logic [2*W-1:0] res;
      int             lat;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;
   sb_t  sb[$];
   vec_t vecs[11];

   always #5 clk = ~clk;

   div_radix2_if #(.WIDTH(W)) bus ();

   div_radix2 #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      bus.annul_i      = 1'b0;
   endtask

   // Accept, scramble operands, wait (bounded) for ready_o, compare against the
   // scoreboard, optionally hold start_i, then release and check the drop.
   task automatic run_op(input vec_t v, input int hold);
      int           n;
      sb_t          e;
      logic [2*W-1:0] held;
      @(negedge clk);
      drive(v.sgn, v.a, v.b);
      sb.push_back('{v.name, v.exp, v.lat});
      @(posedge clk);
      #1;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = ~v.sgn;
      n = 0;
      while (n < 100 && bus.ready_o !== 1'b1) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sb.size() == 0) begin
         check({v.name, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({e.name, "_latency"}, 64'(n), 64'(e.lat));
         check({e.name, "_result"}, bus.result_o, e.res);
      end
      held = bus.result_o;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s_hold_ready_%0d", v.name, i), 64'(bus.ready_o), 64'd1);
         check($sformatf("%s_hold_result_%0d", v.name, i), bus.result_o, held);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      check({v.name, "_release_ready"}, 64'(bus.ready_o), 64'd0);
      check({v.name, "_release_result"}, bus.result_o, 64'd0);
   endtask

   initial begin
      int   seen;
      int   n;
      logic [2*W-1:0] end_res;

      // Expected results are {remainder, quotient}; divide-by-zero takes one
      // cycle for accept plus one more edge.
      vecs[0]  = '{"u_100_7",     1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},               32};
      vecs[1]  = '{"s_m7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  32};
      vecs[2]  = '{"s_min_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000},         32};
      vecs[3]  = '{"u_max_1",     1'b0, 32'hFFFFFFFF, 32'd1,        {32'h0, 32'hFFFFFFFF},         32};
      vecs[4]  = '{"u_div0",      1'b0, 32'd5,        32'd0,        64'd0,                         1};
      vecs[5]  = '{"s_m100_7",    1'b1, 32'hFFFFFF9C, 32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2},  32};
      vecs[6]  = '{"s_100_m7",    1'b1, 32'd100,      32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2},         32};
      vecs[7]  = '{"u_big_div",   1'b0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1},         32};
      vecs[8]  = '{"u_m7_as_u",   1'b0, 32'hFFFFFFF9, 32'd2,        {32'd1, 32'h7FFFFFFC},         32};
      vecs[9]  = '{"s_div0",      1'b1, 32'hFFFFFFF4, 32'd0,        64'd0,                         1};
      vecs[10] = '{"u_13_4",      1'b0, 32'd13,       32'd4,        {32'd1, 32'd3},                32};

      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      rst = 1'b1;
      #1;
      check("reset_ready", 64'(bus.ready_o), 64'd0);
      check("reset_result", bus.result_o, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(vecs[0], 5);
      for (int i = 1; i < 10; i++) run_op(vecs[i], 0);

      // Annul ten edges into ON: the operation vanishes without ready_o.
      @(negedge clk);
      drive(1'b0, 32'd100, 32'd7);
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      check("annul_ready", 64'(bus.ready_o), 64'd0);
      check("annul_result", bus.result_o, 64'd0);
      @(negedge clk);
      bus.annul_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) seen = 1;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
      run_op(vecs[10], 0);

      // annul_i wins over start_i in FREE, so even a divide-by-zero never completes.
      @(negedge clk);
      drive(1'b0, 32'd9, 32'd0);
      bus.annul_i = 1'b1;
      seen = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) seen = 1;
      end
      check("annul_in_free", 64'(seen), 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      @(posedge clk);

      // Reset between edges mid-ON.
      @(negedge clk);
      drive(1'b0, 32'd100, 32'd7);
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_on_ready", 64'(bus.ready_o), 64'd0);
      check("rst_on_result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Reset between edges in END drops a live result without a clock.
      @(negedge clk);
      drive(1'b0, 32'd100, 32'd7);
      n = 0;
      while (n < 100 && bus.ready_o !== 1'b1) begin
         @(posedge clk);
         #1;
         n++;
      end
      end_res = bus.result_o;
      check("rst_end_reached", end_res, {32'd2, 32'd14});
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_end_ready", 64'(bus.ready_o), 64'd0);
      check("rst_end_result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      run_op(vecs[1], 0);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
